// File: rtl/gen_m_mem_responder.sv
// gen_m_mem_responder
//   Memory-backed slave for the gen_m master port of the reverse accelerator
//   core. It stands in for the AXI fabric, memctl and SDRAM models so the core
//   can run against a single-cycle on-chip RAM. One burst is handled at a time:
//   a write burst followed by its response, or a read burst.
//
// Ports
//   axi_clk, axi_rstn        clock, asynchronous active-low reset
//   gen_m0_maddr/mburst/mlen/msize/mid
//                            command fields, sampled on the accept cycle only
//   gen_m0_mread, mwrite     read request / write request and write beat valid
//   gen_m0_mdata, mwstrb     write data and byte enables
//   gen_m0_mready            master accepts the write response or a read beat
//   gen_m0_mcache/mprot/mlock
//                            not used
//   gen_m0_saccept           command or write beat accepted this cycle
//   gen_m0_svalid/sdata/sid/slast/sresp
//                            read beat or write response channel

module gen_m_mem_responder #(
    parameter int AXI_DW    = 512,
    parameter int AXI_AW    = 64,
    parameter int AXI_MIDW  = 4,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                  axi_clk,
    input  logic                  axi_rstn,
    input  logic [AXI_AW-1:0]     gen_m0_maddr,
    input  logic [1:0]            gen_m0_mburst,
    input  logic [3:0]            gen_m0_mlen,
    input  logic [2:0]            gen_m0_msize,
    input  logic [AXI_MIDW-1:0]   gen_m0_mid,
    input  logic                  gen_m0_mread,
    input  logic                  gen_m0_mwrite,
    input  logic [AXI_DW-1:0]     gen_m0_mdata,
    input  logic [AXI_DW/8-1:0]   gen_m0_mwstrb,
    input  logic                  gen_m0_mready,
    input  logic [3:0]            gen_m0_mcache,
    input  logic [2:0]            gen_m0_mprot,
    input  logic                  gen_m0_mlock,
    output logic                  gen_m0_saccept,
    output logic                  gen_m0_svalid,
    output logic [AXI_DW-1:0]     gen_m0_sdata,
    output logic [AXI_MIDW-1:0]   gen_m0_sid,
    output logic                  gen_m0_slast,
    output logic [2:0]            gen_m0_sresp
);

    localparam int WB = $clog2(AXI_DW / 8);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int NBYTES = AXI_DW / 8;
    localparam logic [AXI_AW-1:0] ADDR_LIMIT = AXI_AW'(MEM_DEPTH * NBYTES);
    localparam logic [2:0] SIZE_LEGAL = 3'(WB);

    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [AXI_MIDW-1:0] cur_id;
    logic [3:0]          cur_len;
    logic [1:0]          cur_burst;
    logic [IW-1:0]       cur_idx;
    logic                cur_err;
    logic [3:0]          beat_cnt;

    logic [AXI_DW-1:0]   mem [MEM_DEPTH];
    logic [AXI_DW-1:0]   rdata_q;

    logic [IW-1:0]       cmd_idx;
    logic                cmd_err;
    logic                mem_we;
    logic [IW-1:0]       mem_widx;
    logic                mem_re;
    logic [IW-1:0]       mem_ridx;
    logic                rd_last;

    // Cache, protection and lock attributes have no meaning for a plain RAM.
    logic unused_inputs;
    assign unused_inputs = ^{gen_m0_mcache, gen_m0_mprot, gen_m0_mlock};

    assign cmd_idx = gen_m0_maddr[WB +: IW];
    assign rd_last = (beat_cnt == cur_len);

    // Any one of these makes the whole burst an error: no RAM writes, zero
    // read data, SLVERR on every beat / the response.
    always_comb begin
        cmd_err = 1'b0;
        if (gen_m0_maddr >= ADDR_LIMIT)
            cmd_err = 1'b1;
        if (gen_m0_msize != SIZE_LEGAL)
            cmd_err = 1'b1;
        if (gen_m0_mburst == 2'd3)
            cmd_err = 1'b1;
        if (gen_m0_mburst == 2'd2 &&
            !(gen_m0_mlen == 4'd1 || gen_m0_mlen == 4'd3 ||
              gen_m0_mlen == 4'd7 || gen_m0_mlen == 4'd15))
            cmd_err = 1'b1;
    end

    // For a legal WRAP, mlen is 2^n-1, so it doubles as the mask of the
    // index bits that wrap; upper bits stay put.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx,
                                               input logic [1:0]    burst,
                                               input logic [3:0]    len);
        logic [IW-1:0] inc;
        logic [IW-1:0] mask;
        inc  = idx + IW'(1);
        mask = IW'(len);
        case (burst)
            2'd1:    next_idx = inc;
            2'd2:    next_idx = (idx & ~mask) | (inc & mask);
            default: next_idx = idx;
        endcase
    endfunction

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (gen_m0_mwrite)
                    state_nx = (gen_m0_mlen == 4'd0) ? WRESP : WDATA;
                else if (gen_m0_mread)
                    state_nx = RDATA;
            end
            WDATA: begin
                if (gen_m0_mwrite && beat_cnt == cur_len)
                    state_nx = WRESP;
            end
            WRESP: begin
                if (gen_m0_mready)
                    state_nx = IDLE;
            end
            RDATA: begin
                if (gen_m0_mready && rd_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gen_m0_saccept = 1'b0;
        gen_m0_svalid  = 1'b0;
        gen_m0_slast   = 1'b0;
        gen_m0_sdata   = '0;
        gen_m0_sid     = '0;
        gen_m0_sresp   = RESP_OKAY;
        case (state)
            IDLE:  gen_m0_saccept = gen_m0_mwrite | gen_m0_mread;
            WDATA: gen_m0_saccept = gen_m0_mwrite;
            WRESP: begin
                gen_m0_svalid = 1'b1;
                gen_m0_slast  = 1'b1;
                gen_m0_sid    = cur_id;
                gen_m0_sresp  = cur_err ? RESP_SLVERR : RESP_OKAY;
            end
            RDATA: begin
                gen_m0_svalid = 1'b1;
                gen_m0_slast  = rd_last;
                gen_m0_sid    = cur_id;
                gen_m0_sdata  = cur_err ? '0 : rdata_q;
                gen_m0_sresp  = cur_err ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    // RAM port control. Beat 0 of a write lands in the accept cycle, using the
    // index straight from the command. A read pre-fetches the first word at
    // accept and each following word in the handshake of the previous beat,
    // so beats stream with no bubble.
    always_comb begin
        mem_we   = 1'b0;
        mem_widx = cur_idx;
        mem_re   = 1'b0;
        mem_ridx = cur_idx;
        case (state)
            IDLE: begin
                mem_widx = cmd_idx;
                mem_ridx = cmd_idx;
                mem_we   = gen_m0_mwrite & ~cmd_err;
                mem_re   = gen_m0_mread & ~gen_m0_mwrite;
            end
            WDATA: mem_we = gen_m0_mwrite & ~cur_err;
            RDATA: mem_re = gen_m0_mready & ~rd_last;
            default: ;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (gen_m0_mwstrb[b])
                    mem[mem_widx][b*8 +: 8] <= gen_m0_mdata[b*8 +: 8];
            end
        end
        if (mem_re)
            rdata_q <= mem[mem_ridx];
    end

    // cur_idx always points at the next word to be written or pre-read;
    // beat_cnt is the number of write beats taken, or the index of the read
    // beat currently presented.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            cur_id    <= '0;
            cur_len   <= '0;
            cur_burst <= '0;
            cur_idx   <= '0;
            cur_err   <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gen_m0_mwrite || gen_m0_mread) begin
                        cur_id    <= gen_m0_mid;
                        cur_len   <= gen_m0_mlen;
                        cur_burst <= gen_m0_mburst;
                        cur_err   <= cmd_err;
                        cur_idx   <= next_idx(cmd_idx, gen_m0_mburst, gen_m0_mlen);
                        beat_cnt  <= gen_m0_mwrite ? 4'd1 : 4'd0;
                    end
                end
                WDATA: begin
                    if (gen_m0_mwrite) begin
                        cur_idx  <= next_idx(cur_idx, cur_burst, cur_len);
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                RDATA: begin
                    if (gen_m0_mready && !rd_last) begin
                        cur_idx  <= next_idx(cur_idx, cur_burst, cur_len);
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gen_m_mem_responder.sv
// tb_gen_m_mem_responder
//   Self-checking bench for gen_m_mem_responder. A word-array model of the RAM
//   tracks every write; burst addressing and error rules are computed with
//   plain arithmetic from the command fields.

module tb_gen_m_mem_responder;

    localparam int DW    = 512;
    localparam int AW    = 64;
    localparam int IDW   = 4;
    localparam int DEPTH = 1024;
    localparam int NB    = DW / 8;
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH * NB);

    typedef logic [DW-1:0] word_t;

    logic            axi_clk = 1'b0;
    logic            axi_rstn;
    logic [AW-1:0]   gen_m0_maddr;
    logic [1:0]      gen_m0_mburst;
    logic [3:0]      gen_m0_mlen;
    logic [2:0]      gen_m0_msize;
    logic [IDW-1:0]  gen_m0_mid;
    logic            gen_m0_mread;
    logic            gen_m0_mwrite;
    logic [DW-1:0]   gen_m0_mdata;
    logic [NB-1:0]   gen_m0_mwstrb;
    logic            gen_m0_mready;
    logic [3:0]      gen_m0_mcache;
    logic [2:0]      gen_m0_mprot;
    logic            gen_m0_mlock;
    logic            gen_m0_saccept;
    logic            gen_m0_svalid;
    logic [DW-1:0]   gen_m0_sdata;
    logic [IDW-1:0]  gen_m0_sid;
    logic            gen_m0_slast;
    logic [2:0]      gen_m0_sresp;

    word_t model_mem [DEPTH];
    int    pass_cnt  = 0;
    int    fail_cnt  = 0;
    int    check_cnt = 0;

    gen_m_mem_responder #(
        .AXI_DW(DW), .AXI_AW(AW), .AXI_MIDW(IDW), .MEM_DEPTH(DEPTH)
    ) dut (
        .axi_clk        (axi_clk),
        .axi_rstn       (axi_rstn),
        .gen_m0_maddr   (gen_m0_maddr),
        .gen_m0_mburst  (gen_m0_mburst),
        .gen_m0_mlen    (gen_m0_mlen),
        .gen_m0_msize   (gen_m0_msize),
        .gen_m0_mid     (gen_m0_mid),
        .gen_m0_mread   (gen_m0_mread),
        .gen_m0_mwrite  (gen_m0_mwrite),
        .gen_m0_mdata   (gen_m0_mdata),
        .gen_m0_mwstrb  (gen_m0_mwstrb),
        .gen_m0_mready  (gen_m0_mready),
        .gen_m0_mcache  (gen_m0_mcache),
        .gen_m0_mprot   (gen_m0_mprot),
        .gen_m0_mlock   (gen_m0_mlock),
        .gen_m0_saccept (gen_m0_saccept),
        .gen_m0_svalid  (gen_m0_svalid),
        .gen_m0_sdata   (gen_m0_sdata),
        .gen_m0_sid     (gen_m0_sid),
        .gen_m0_slast   (gen_m0_slast),
        .gen_m0_sresp   (gen_m0_sresp)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic word_t rand_word();
        word_t w = '0;
        for (int i = 0; i < DW / 32; i++)
            w = {w[DW-33:0], 32'($urandom())};
        return w;
    endfunction

    function automatic logic model_err(input logic [AW-1:0] addr, input logic [2:0] size,
                                       input logic [1:0] burst, input int len);
        int n = len + 1;
        if (addr >= LIMIT) return 1'b1;
        if (size != 3'd6) return 1'b1;
        if (burst == 2'd3) return 1'b1;
        if (burst == 2'd2 && !(n == 2 || n == 4 || n == 8 || n == 16)) return 1'b1;
        return 1'b0;
    endfunction

    // Word addressed by beat k of a burst.
    function automatic int beat_word(input logic [AW-1:0] addr, input logic [1:0] burst,
                                     input int len, input int k);
        int start = int'((addr / AW'(NB)) % AW'(DEPTH));
        int n = len + 1;
        case (burst)
            2'd1:    return (start + k) % DEPTH;
            2'd2:    return (start - (start % n)) + ((start % n) + k) % n;
            default: return start;
        endcase
    endfunction

    // mode 0: always ready; 1: toggles 1,0,1,0...; 2: random, forced ready later on.
    function automatic logic ready_at(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return (cyc >= 12) ? 1'b1 : ($urandom_range(0, 2) != 0);
        endcase
    endfunction

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_saccept"}, word_t'(gen_m0_saccept), '0);
        checkOutput({tag, "_svalid"},  word_t'(gen_m0_svalid),  '0);
        checkOutput({tag, "_slast"},   word_t'(gen_m0_slast),   '0);
        checkOutput({tag, "_sdata"},   word_t'(gen_m0_sdata),   '0);
        checkOutput({tag, "_sid"},     word_t'(gen_m0_sid),     '0);
        checkOutput({tag, "_sresp"},   word_t'(gen_m0_sresp),   '0);
    endtask

    task automatic scramble_cmd();
        gen_m0_maddr  = {32'($urandom()), 32'($urandom())};
        gen_m0_mburst = 2'($urandom());
        gen_m0_mlen   = 4'($urandom());
        gen_m0_msize  = 3'($urandom());
        gen_m0_mid    = 4'($urandom());
    endtask

    // smode 0: full strobe, 1: random strobe, 2: byte 0 only.
    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus_write(input logic [AW-1:0] addr, input logic [1:0] burst,
                                       input int len, input logic [2:0] size,
                                       input logic [IDW-1:0] id, input int rmode, input int smode);
        word_t         data [16];
        logic [NB-1:0] strb [16];
        logic          err;
        logic          done;
        logic          hs;
        int            w;
        int            cyc;
        err = model_err(addr, size, burst, len);
        for (int k = 0; k <= len; k++) begin
            data[k] = rand_word();
            case (smode)
                0:       strb[k] = '1;
                1:       strb[k] = {32'($urandom()), 32'($urandom())};
                default: strb[k] = NB'(1);
            endcase
        end
        gen_m0_maddr  = addr;
        gen_m0_mburst = burst;
        gen_m0_mlen   = 4'(len);
        gen_m0_msize  = size;
        gen_m0_mid    = id;
        for (int k = 0; k <= len; k++) begin
            gen_m0_mwrite = 1'b1;
            gen_m0_mdata  = data[k];
            gen_m0_mwstrb = strb[k];
            @(negedge axi_clk);
            checkOutput($sformatf("wr_accept_b%0d", k), word_t'(gen_m0_saccept), word_t'(1'b1));
            @(posedge axi_clk);
            #1;
            scramble_cmd();
            if (!err) begin
                w = beat_word(addr, burst, len, k);
                for (int b = 0; b < NB; b++)
                    if (strb[k][b]) model_mem[w][b*8 +: 8] = data[k][b*8 +: 8];
            end
        end
        gen_m0_mwrite = 1'b0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 40) begin
            gen_m0_mready = ready_at(rmode, cyc);
            @(negedge axi_clk);
            checkOutput("wr_resp_svalid", word_t'(gen_m0_svalid), word_t'(1'b1));
            checkOutput("wr_resp_slast",  word_t'(gen_m0_slast),  word_t'(1'b1));
            checkOutput("wr_resp_sid",    word_t'(gen_m0_sid),    word_t'(id));
            checkOutput("wr_resp_sresp",  word_t'(gen_m0_sresp),  word_t'(err ? 3'b010 : 3'b000));
            hs = gen_m0_mready;
            @(posedge axi_clk);
            #1;
            done = hs;
            cyc++;
        end
        checkOutput("wr_resp_done", word_t'(done), word_t'(1'b1));
        gen_m0_mready = 1'b0;
        @(negedge axi_clk);
        checkOutput("wr_after_idle", word_t'(gen_m0_svalid), '0);
        @(posedge axi_clk);
        #1;
    endtask

    // reset_at >= 0 asserts reset while that beat is being presented.
    task automatic applyStimulus_read(input logic [AW-1:0] addr, input logic [1:0] burst,
                                      input int len, input logic [2:0] size,
                                      input logic [IDW-1:0] id, input int rmode, input int reset_at);
        logic  err;
        logic  hs;
        int    k;
        int    cyc;
        word_t exp_data;
        err = model_err(addr, size, burst, len);
        gen_m0_maddr  = addr;
        gen_m0_mburst = burst;
        gen_m0_mlen   = 4'(len);
        gen_m0_msize  = size;
        gen_m0_mid    = id;
        gen_m0_mread  = 1'b1;
        @(negedge axi_clk);
        checkOutput("rd_accept", word_t'(gen_m0_saccept), word_t'(1'b1));
        @(posedge axi_clk);
        #1;
        gen_m0_mread = 1'b0;
        scramble_cmd();
        k   = 0;
        cyc = 0;
        while (k <= len && cyc < 80) begin
            if (k == reset_at) begin
                axi_rstn = 1'b0;
                #1;
                check_idle_outputs("rst_mid");
                @(negedge axi_clk);
                checkOutput("rst_mid_svalid_hold", word_t'(gen_m0_svalid), '0);
                axi_rstn = 1'b1;
                @(posedge axi_clk);
                #1;
                gen_m0_mready = 1'b0;
                return;
            end
            gen_m0_mready = ready_at(rmode, cyc);
            exp_data = err ? '0 : model_mem[beat_word(addr, burst, len, k)];
            @(negedge axi_clk);
            checkOutput($sformatf("rd_svalid_b%0d", k), word_t'(gen_m0_svalid), word_t'(1'b1));
            checkOutput($sformatf("rd_sdata_b%0d", k),  gen_m0_sdata, exp_data);
            checkOutput($sformatf("rd_slast_b%0d", k),  word_t'(gen_m0_slast), word_t'(k == len));
            checkOutput($sformatf("rd_sid_b%0d", k),    word_t'(gen_m0_sid), word_t'(id));
            checkOutput($sformatf("rd_sresp_b%0d", k),  word_t'(gen_m0_sresp),
                        word_t'(err ? 3'b010 : 3'b000));
            hs = gen_m0_mready;
            @(posedge axi_clk);
            #1;
            if (hs) k++;
            cyc++;
        end
        checkOutput("rd_beat_count", word_t'(k), word_t'(len + 1));
        gen_m0_mready = 1'b0;
        @(negedge axi_clk);
        checkOutput("rd_after_idle", word_t'(gen_m0_svalid), '0);
        @(posedge axi_clk);
        #1;
    endtask

    initial begin
        logic [AW-1:0] addr;
        logic [1:0]    burst;
        logic [2:0]    size;
        int            len;

        axi_rstn      = 1'b0;
        gen_m0_maddr  = '0;
        gen_m0_mburst = 2'd1;
        gen_m0_mlen   = '0;
        gen_m0_msize  = 3'd6;
        gen_m0_mid    = '0;
        gen_m0_mread  = 1'b0;
        gen_m0_mwrite = 1'b0;
        gen_m0_mdata  = '0;
        gen_m0_mwstrb = '0;
        gen_m0_mready = 1'b0;
        gen_m0_mcache = '0;
        gen_m0_mprot  = '0;
        gen_m0_mlock  = 1'b0;

        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        check_idle_outputs("por");
        axi_rstn = 1'b1;
        @(posedge axi_clk);
        #1;

        $display("[TB] filling RAM");
        for (int i = 0; i < DEPTH / 16; i++)
            applyStimulus_write(AW'(i * 16 * NB), 2'd1, 15, 3'd6, 4'(i), 0, 0);

        $display("[TB] directed INCR write / read-back");
        applyStimulus_write(64'h0, 2'd1, 3, 3'd6, 4'h5, 0, 0);
        applyStimulus_read(64'h0, 2'd1, 3, 3'd6, 4'h6, 0, -1);

        $display("[TB] WRAP read from word 2");
        applyStimulus_read(AW'(2 * NB), 2'd2, 3, 3'd6, 4'h7, 0, -1);
        applyStimulus_read(AW'(2 * NB), 2'd2, 3, 3'd6, 4'h8, 1, -1);

        $display("[TB] byte-strobe write to word 5");
        applyStimulus_write(AW'(5 * NB), 2'd1, 0, 3'd6, 4'h3, 0, 2);
        applyStimulus_read(AW'(5 * NB), 2'd0, 0, 3'd6, 4'h3, 0, -1);

        $display("[TB] error bursts");
        applyStimulus_write(LIMIT, 2'd1, 1, 3'd6, 4'hA, 0, 0);
        applyStimulus_read(64'h0, 2'd1, 1, 3'd6, 4'hA, 0, -1);
        applyStimulus_write(AW'(8 * NB), 2'd1, 1, 3'd3, 4'hB, 0, 0);
        applyStimulus_read(AW'(8 * NB), 2'd1, 1, 3'd6, 4'hB, 0, -1);
        applyStimulus_write(AW'(12 * NB), 2'd2, 2, 3'd6, 4'hC, 2, 0);
        applyStimulus_read(AW'(12 * NB), 2'd1, 3, 3'd6, 4'hC, 0, -1);
        applyStimulus_read(LIMIT, 2'd1, 2, 3'd6, 4'hD, 0, -1);
        applyStimulus_read(AW'(8 * NB), 2'd1, 1, 3'd3, 4'hD, 0, -1);
        applyStimulus_read(AW'(12 * NB), 2'd2, 2, 3'd6, 4'hE, 2, -1);
        applyStimulus_read(AW'(20 * NB), 2'd3, 3, 3'd6, 4'hE, 0, -1);

        $display("[TB] reset during read beat 2");
        applyStimulus_read(AW'(32 * NB), 2'd1, 7, 3'd6, 4'h9, 0, 2);
        applyStimulus_read(AW'(32 * NB), 2'd1, 7, 3'd6, 4'h4, 0, -1);

        $display("[TB] randomized bursts");
        for (int i = 0; i < 60; i++) begin
            addr  = AW'($urandom_range(0, DEPTH - 1) * NB + $urandom_range(0, NB - 1));
            if ($urandom_range(0, 7) == 0)
                addr = LIMIT + AW'($urandom_range(0, 4095));
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0)
                burst = 2'd3;
            len = $urandom_range(0, 15);
            if (burst == 2'd2 && $urandom_range(0, 4) != 0)
                len = (2 << $urandom_range(0, 3)) - 1;
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 5)) : 3'd6;
            if ($urandom_range(0, 1) == 0)
                applyStimulus_write(addr, burst, len, size, 4'($urandom()),
                                    $urandom_range(0, 2), 1);
            else
                applyStimulus_read(addr, burst, len, size, 4'($urandom()),
                                   $urandom_range(0, 2), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
